// File: rtl/csync_pkg.sv
// Shared definitions for the PAL composite-sync generator.
// Holds the tick-conversion helper, the default timing set and the derived
// constants for that default set (102 MHz PLL, 15666 Hz lines, 313 lines).
package csync_pkg;

    // Default timing set
    localparam real DEF_PLL_FREQ    = 102.0e6;
    localparam int  DEF_HSYNC_FREQ  = 15666;
    localparam int  DEF_FRAME_LINES = 313;
    localparam real DEF_PULSE_WIDTH = 5.0e-6;
    localparam int  DEF_VSYNC_LINES = 3;

    // Converts a real ratio to a whole number of clock ticks (truncating).
    // The tiny bias keeps values such as 509.99999999 (binary fp error on
    // 102e6 * 5e-6) from truncating one tick short.
    function automatic int csync_ticks(input real amount, input real divisor);
        return $rtoi(amount / divisor + 1.0e-6);
    endfunction

    // True when a timing set leaves room for both pulses and a visible region.
    function automatic bit csync_timing_ok(input int line_ticks, input int pulse_ticks,
                                           input int frame_lines, input int vsync_lines);
        return (line_ticks >= 2 * pulse_ticks + 2) && (vsync_lines < frame_lines);
    endfunction

    // Derived constants for the default timing set
    localparam int DEF_LINE_TICKS     = csync_ticks(DEF_PLL_FREQ, real'(DEF_HSYNC_FREQ));
    localparam int DEF_PULSE_TICKS    = csync_ticks(DEF_PLL_FREQ * DEF_PULSE_WIDTH, 1.0);
    localparam int DEF_HSYNC_HIGH_DOT = DEF_LINE_TICKS - 2 * DEF_PULSE_TICKS - 1;
    localparam int DEF_HSYNC_LOW_DOT  = DEF_LINE_TICKS - DEF_PULSE_TICKS - 1;
    localparam int DEF_DW             = $clog2(DEF_LINE_TICKS);
    localparam int DEF_LW             = $clog2(DEF_FRAME_LINES);

    typedef logic [DEF_DW-1:0] dot_t;
    typedef logic [DEF_LW-1:0] line_t;

endpackage

// File: rtl/wrap_counter.sv
// Modulo counter used for both the dot and the line position.
// Counts 0..MAX on inc, returns to 0 after MAX; clr forces 0 and wins over inc.
// wrap flags the tick on which the counter leaves MAX, so it can drive the
// next counter in a chain.
module wrap_counter
    import csync_pkg::*;
#(
    parameter int MAX = 9,
    parameter int W   = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         inc,
    input  logic         clr,
    output logic [W-1:0] q,
    output logic         wrap
);

    localparam logic [W-1:0] MAX_C = W'(MAX);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    assign wrap = inc && (cnt_q == MAX_C);
    assign q    = cnt_q;

    // Next count: clear, wrap at MAX, or step by one
    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (inc) begin
            cnt_d = wrap ? '0 : cnt_q + W'(1);
        end
    end

    // Count register with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/pal_csync_gen.sv
// PAL composite-sync generator for the Atari video path.
// Dot and line counters run off the PLL clock under a tick enable; hsync_n,
// vsync_n, csync_n and the line/frame strobes are registered decodes of the
// counter value seen on each enabled tick, so they trail the counters by one
// enabled tick. restart re-aligns both counters to dot 0, line 0.
// Build option: define CSYNC_SERRATION_EN to emit broad pulses on the vsync
// lines (csync_n high only just before the hsync position); otherwise
// csync_n stays low for the whole of every vsync line.
module pal_csync_gen
    import csync_pkg::*;
#(
    parameter  real PLL_FREQ       = DEF_PLL_FREQ,
    parameter  int  HSYNC_FREQ     = DEF_HSYNC_FREQ,
    parameter  int  FRAME_LINES    = DEF_FRAME_LINES,
    parameter  real PULSE_WIDTH    = DEF_PULSE_WIDTH,
    parameter  int  VSYNC_LINES    = DEF_VSYNC_LINES,
    localparam int  LINE_TICKS     = csync_ticks(PLL_FREQ, real'(HSYNC_FREQ)),
    localparam int  PULSE_TICKS    = csync_ticks(PLL_FREQ * PULSE_WIDTH, 1.0),
    localparam int  HSYNC_HIGH_DOT = LINE_TICKS - 2 * PULSE_TICKS - 1,
    localparam int  HSYNC_LOW_DOT  = LINE_TICKS - PULSE_TICKS - 1,
    localparam int  DW             = $clog2(LINE_TICKS),
    localparam int  LW             = $clog2(FRAME_LINES)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          en,
    input  logic          restart,
    output logic [DW-1:0] dot,
    output logic [LW-1:0] line,
    output logic          hsync_n,
    output logic          vsync_n,
    output logic          csync_n,
    output logic          line_start,
    output logic          frame_start
);

    // Reject timing sets with no room for the pulses or with vsync filling the frame
    if (LINE_TICKS < 2 * PULSE_TICKS + 2) begin : g_bad_line_timing
        $error("pal_csync_gen: LINE_TICKS (%0d) < 2*PULSE_TICKS+2 (%0d)",
               LINE_TICKS, 2 * PULSE_TICKS + 2);
    end
    if (VSYNC_LINES >= FRAME_LINES) begin : g_bad_frame_timing
        $error("pal_csync_gen: VSYNC_LINES (%0d) >= FRAME_LINES (%0d)",
               VSYNC_LINES, FRAME_LINES);
    end

    // Decode thresholds at counter width
    localparam logic [DW-1:0] HIGH_DOT_C    = DW'(HSYNC_HIGH_DOT);
    localparam logic [DW-1:0] LOW_DOT_C     = DW'(HSYNC_LOW_DOT);
    localparam logic [LW-1:0] VSYNC_FIRST_C = LW'(FRAME_LINES - VSYNC_LINES);

    logic [DW-1:0] dot_q;
    logic [LW-1:0] line_q;
    logic          dot_wrap;
    logic          frame_wrap_unused;
    logic          realign;

    logic          hsync_n_q,     hsync_n_d;
    logic          vsync_n_q,     vsync_n_d;
    logic          csync_n_q,     csync_n_d;
    logic          line_start_q,  line_start_d;
    logic          frame_start_q, frame_start_d;

    logic          hsync_zone;
    logic          vsync_zone;
    logic          broad_gap;

    // restart only takes effect on an enabled tick
    assign realign = en && restart;

    wrap_counter #(
        .MAX (LINE_TICKS - 1),
        .W   (DW)
    ) u_dot_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (en),
        .clr   (realign),
        .q     (dot_q),
        .wrap  (dot_wrap)
    );

    wrap_counter #(
        .MAX (FRAME_LINES - 1),
        .W   (LW)
    ) u_line_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (dot_wrap),
        .clr   (realign),
        .q     (line_q),
        .wrap  (frame_wrap_unused)
    );

    // Sync and strobe decode of the current counter value
    always_comb begin
        hsync_zone    = 1'b0;
        vsync_zone    = 1'b0;
        broad_gap     = 1'b0;
        hsync_n_d     = 1'b1;
        vsync_n_d     = 1'b1;
        csync_n_d     = 1'b1;
        line_start_d  = 1'b0;
        frame_start_d = 1'b0;

        hsync_zone = (dot_q > LOW_DOT_C);
        vsync_zone = (line_q >= VSYNC_FIRST_C);
        // Short high gap that ends each broad pulse, one pulse width before the hsync fall
        broad_gap  = (dot_q > HIGH_DOT_C) && (dot_q <= LOW_DOT_C);

        hsync_n_d = !hsync_zone;
        vsync_n_d = !vsync_zone;

        if (vsync_zone) begin
`ifdef CSYNC_SERRATION_EN
            csync_n_d = broad_gap;
`else
            csync_n_d = 1'b0;
`endif
        end else begin
            csync_n_d = hsync_n_d;
        end

        line_start_d  = (dot_q == '0);
        frame_start_d = (dot_q == '0) && (line_q == '0);
    end

    // Output registers: load on enabled ticks, hold otherwise
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            hsync_n_q     <= 1'b1;
            vsync_n_q     <= 1'b1;
            csync_n_q     <= 1'b1;
            line_start_q  <= 1'b0;
            frame_start_q <= 1'b0;
        end else if (en) begin
            hsync_n_q     <= hsync_n_d;
            vsync_n_q     <= vsync_n_d;
            csync_n_q     <= csync_n_d;
            line_start_q  <= line_start_d;
            frame_start_q <= frame_start_d;
        end
    end

    assign dot         = dot_q;
    assign line        = line_q;
    assign hsync_n     = hsync_n_q;
    assign vsync_n     = vsync_n_q;
    assign csync_n     = csync_n_q;
    assign line_start  = line_start_q;
    assign frame_start = frame_start_q;

endmodule

// File: tb/tb_pal_csync_gen.sv
// Testbench for pal_csync_gen with a scaled-down timing set (20 dots/line,
// 3-dot pulses, 10 lines/frame, 3 vsync lines) so whole frames fit in a
// short run. The reference model tracks a single position within the frame
// and derives every output from it with plain arithmetic.
module tb_pal_csync_gen;

    localparam int LT = 20;        // dots per line
    localparam int PT = 3;         // pulse width in dots
    localparam int FL = 10;        // lines per frame
    localparam int VL = 3;         // vsync lines
    localparam int FT = LT * FL;   // dots per frame

    logic       clk = 1'b0;
    logic       rst_n;
    logic       en;
    logic       restart;
    logic [4:0] dot;
    logic [3:0] line;
    logic       hsync_n;
    logic       vsync_n;
    logic       csync_n;
    logic       line_start;
    logic       frame_start;

    pal_csync_gen #(
        .PLL_FREQ    (1000.0),
        .HSYNC_FREQ  (50),
        .FRAME_LINES (FL),
        .PULSE_WIDTH (0.003),
        .VSYNC_LINES (VL)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .en          (en),
        .restart     (restart),
        .dot         (dot),
        .line        (line),
        .hsync_n     (hsync_n),
        .vsync_n     (vsync_n),
        .csync_n     (csync_n),
        .line_start  (line_start),
        .frame_start (frame_start)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model state
    int   m_pos = 0;
    logic m_hs = 1'b1, m_vs = 1'b1, m_cs = 1'b1, m_ls = 1'b0, m_fs = 1'b0;

    // Observed statistics over a measurement window
    int   cyc = 0;
    int   n_hs_low, n_vs_low, n_cs_high_vs, n_ls_rise, n_fs_rise, last_fs, fs_period;
    logic prev_fs, prev_ls;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s observed=%0d expected=%0d (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    task automatic stats_clear();
        n_hs_low     = 0;
        n_vs_low     = 0;
        n_cs_high_vs = 0;
        n_ls_rise    = 0;
        n_fs_rise    = 0;
        last_fs      = -1;
        fs_period    = 0;
        prev_fs      = frame_start;
        prev_ls      = line_start;
    endtask

    // Advance the model across one clock edge with the given inputs
    task automatic model_edge(input logic r, input logic e, input logic s);
        int d;
        int l;
        if (!r) begin
            m_pos = 0;
            m_hs  = 1'b1;
            m_vs  = 1'b1;
            m_cs  = 1'b1;
            m_ls  = 1'b0;
            m_fs  = 1'b0;
        end else if (e) begin
            d    = m_pos % LT;
            l    = m_pos / LT;
            m_hs = !(d >= LT - PT);
            m_vs = !(l >= FL - VL);
            if (m_vs) begin
                m_cs = m_hs;
            end else begin
`ifdef CSYNC_SERRATION_EN
                m_cs = (d >= LT - 2 * PT) && (d < LT - PT);
`else
                m_cs = 1'b0;
`endif
            end
            m_ls  = (d == 0);
            m_fs  = (m_pos == 0);
            m_pos = s ? 0 : (m_pos + 1) % FT;
        end
    endtask

    // One clock: drive inputs, let the edge happen, compare on the falling edge
    task automatic tick(input logic r, input logic e, input logic s);
        rst_n   = r;
        en      = e;
        restart = s;
        @(posedge clk);
        model_edge(r, e, s);
        @(negedge clk);
        cyc++;
        chk("dot",         32'(dot),         32'(m_pos % LT));
        chk("line",        32'(line),        32'(m_pos / LT));
        chk("hsync_n",     32'(hsync_n),     32'(m_hs));
        chk("vsync_n",     32'(vsync_n),     32'(m_vs));
        chk("csync_n",     32'(csync_n),     32'(m_cs));
        chk("line_start",  32'(line_start),  32'(m_ls));
        chk("frame_start", 32'(frame_start), 32'(m_fs));
        if (!hsync_n) n_hs_low++;
        if (!vsync_n) n_vs_low++;
        if (!vsync_n && csync_n) n_cs_high_vs++;
        if (line_start && !prev_ls) n_ls_rise++;
        if (frame_start && !prev_fs) begin
            n_fs_rise++;
            if (last_fs >= 0) fs_period = cyc - last_fs;
            last_fs = cyc;
        end
        prev_fs = frame_start;
        prev_ls = line_start;
    endtask

    // Run enabled ticks until the model reaches a frame position (bounded)
    task automatic run_to(input int target, input string tag);
        for (int i = 0; i < FT + 1; i++) begin
            if (m_pos == target) break;
            tick(1'b1, 1'b1, 1'b0);
        end
        chk(tag, 32'(m_pos), 32'(target));
    endtask

    int held;

    initial begin
        rst_n   = 1'b0;
        en      = 1'b0;
        restart = 1'b0;
        @(negedge clk);

        // Reset wins over en and restart
        tick(1'b0, 1'b1, 1'b1);
        tick(1'b0, 1'b0, 1'b0);
        chk("rst_dot",    32'(dot),     32'd0);
        chk("rst_csync",  32'(csync_n), 32'd1);

        // Free run for two frames
        stats_clear();
        repeat (2 * FT) tick(1'b1, 1'b1, 1'b0);
        chk("run_hs_low",    32'(n_hs_low),  32'(2 * FL * PT));
        chk("run_vs_low",    32'(n_vs_low),  32'(2 * VL * LT));
        chk("run_ls_count",  32'(n_ls_rise), 32'(2 * FL));
        chk("run_fs_count",  32'(n_fs_rise), 32'd2);
        chk("run_fs_period", 32'(fs_period), 32'(FT));
`ifdef CSYNC_SERRATION_EN
        chk("run_cs_broad_gap", 32'(n_cs_high_vs), 32'(2 * VL * PT));
`else
        chk("run_cs_broad_gap", 32'(n_cs_high_vs), 32'd0);
`endif

        // Reset while enabled in mid-line
        run_to(5 * LT + 10, "reach_midline");
        tick(1'b0, 1'b1, 1'b0);
        chk("midrst_dot",   32'(dot),         32'd0);
        chk("midrst_line",  32'(line),        32'd0);
        chk("midrst_hsync", 32'(hsync_n),     32'd1);
        chk("midrst_fs",    32'(frame_start), 32'd0);

        // en toggling every cycle: periods double, outputs hold while en=0
        stats_clear();
        repeat (2 * FT) begin
            tick(1'b1, 1'b1, 1'b0);
            tick(1'b1, 1'b0, 1'b0);
        end
        chk("half_hs_low",    32'(n_hs_low),  32'(4 * FL * PT));
        chk("half_vs_low",    32'(n_vs_low),  32'(4 * VL * LT));
        chk("half_fs_count",  32'(n_fs_rise), 32'd2);
        chk("half_fs_period", 32'(fs_period), 32'(2 * FT));

        // restart right at the wrap point: single frame strobe
        run_to(FT - 1, "reach_wrap");
        stats_clear();
        tick(1'b1, 1'b1, 1'b1);
        chk("wrap_rst_dot",  32'(dot),  32'd0);
        chk("wrap_rst_line", 32'(line), 32'd0);
        repeat (5) tick(1'b1, 1'b1, 1'b0);
        chk("wrap_fs_once", 32'(n_fs_rise), 32'd1);
        chk("wrap_ls_once", 32'(n_ls_rise), 32'd1);

        // restart while disabled is ignored
        run_to(7 * LT + 4, "reach_hold");
        held = m_pos;
        repeat (3) tick(1'b1, 1'b0, 1'b1);
        chk("hold_dot",  32'(dot),  32'(held % LT));
        chk("hold_line", 32'(line), 32'(held / LT));
        tick(1'b1, 1'b1, 1'b0);
        chk("resume_dot", 32'(dot), 32'((held + 1) % LT));

        // Randomized enable, restart and occasional reset
        for (int i = 0; i < 3000; i++) begin
            tick(($urandom_range(0, 199) != 0),
                 ($urandom_range(0, 3) != 0),
                 ($urandom_range(0, 49) == 0));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
